// File: rtl/turn_cmd_frontend.sv
// Turn-signal front end: synchronises and debounces the left/right/hazard switches,
// generates the step tick, and registers one one-hot command per tick.
module turn_cmd_frontend #(
  parameter int TICK_DIV   = 12_500_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_left,
  input  logic sw_right,
  input  logic sw_hazard,
  output logic tick,
  output logic c_left,
  output logic c_right,
  output logic c_hazard,
  output logic c_noop
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int DW  = $clog2(DEB_CYCLES + 1);
  localparam int NSW = 3;  // bit 0 = left, bit 1 = right, bit 2 = hazard

  typedef enum logic [3:0] {
    CMD_NOOP   = 4'b0001,
    CMD_LEFT   = 4'b0010,
    CMD_RIGHT  = 4'b0100,
    CMD_HAZARD = 4'b1000
  } cmd_e;

  logic [NSW-1:0] raw;
  logic [NSW-1:0] sync1_q, sync2_q;
  logic [NSW-1:0] deb_q, deb_d;
  logic [DW-1:0]  cnt_q [NSW];
  logic [DW-1:0]  cnt_d [NSW];
  logic [TW-1:0]  pc_q, pc_d;
  logic           tick_q, tick_d;
  logic           pc_wrap;
  cmd_e           cmd_q, cmd_d;

  assign raw = {sw_hazard, sw_right, sw_left};

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NSW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign pc_wrap = (pc_q == TW'(TICK_DIV - 1));
  assign pc_d    = pc_wrap ? '0 : pc_q + TW'(1);
  assign tick_d  = pc_wrap;

  // The encoder sees the debounced states from before this edge, so a debounce that
  // completes on the tick edge waits for the following tick.
  always_comb begin
    cmd_d = cmd_q;
    if (pc_wrap) begin
      if (deb_q[2] || (deb_q[0] && deb_q[1])) cmd_d = CMD_HAZARD;
      else if (deb_q[0])                      cmd_d = CMD_LEFT;
      else if (deb_q[1])                      cmd_d = CMD_RIGHT;
      else                                    cmd_d = CMD_NOOP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NSW; i++) cnt_q[i] <= '0;
      pc_q    <= '0;
      tick_q  <= 1'b0;
      cmd_q   <= CMD_NOOP;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < NSW; i++) cnt_q[i] <= cnt_d[i];
      pc_q    <= pc_d;
      tick_q  <= tick_d;
      cmd_q   <= cmd_d;
    end
  end

  assign tick = tick_q;
  assign {c_hazard, c_right, c_left, c_noop} = cmd_q;

endmodule
